// File: rtl/imm_pkg.sv
// Shared decode types for the immediate extender and the control-unit decoder:
// instruction classes, prefix FSM states and the default opcode encodings.
package imm_pkg;

   localparam int                    IMM_OPC_W    = 4;
   localparam logic [IMM_OPC_W-1:0] IMM_LONG_OPC = 4'b0111;
   localparam logic [IMM_OPC_W-1:0] IMM_PFX_OPC  = 4'b0110;

   typedef enum logic [1:0] {SHORT, MID, LONG, PFX} imm_class_e;
   typedef enum logic       {IDLE, HELD}            pfx_state_e;

   // An opcode MSB of 1 always means SHORT, whatever the other opcodes are.
   function automatic imm_class_e classify(input logic [IMM_OPC_W-1:0] opc,
                                           input logic [IMM_OPC_W-1:0] long_opc,
                                           input logic [IMM_OPC_W-1:0] pfx_opc);
      if (opc[IMM_OPC_W-1]) return SHORT;
      if (opc == long_opc)  return LONG;
      if (opc == pfx_opc)   return PFX;
      return MID;
   endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Instruction-in / immediate-out valid-ready bundle of the immediate extender.
interface imm_extend_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_instr;
   logic             in_zext;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_instr;
   logic [WIDTH-1:0] out_imm;
   logic             out_prefixed;

   modport master (
      output in_valid, in_instr, in_zext, out_ready,
      input  in_ready, out_valid, out_instr, out_imm, out_prefixed
   );

   modport slave (
      input  in_valid, in_instr, in_zext, out_ready,
      output in_ready, out_valid, out_instr, out_imm, out_prefixed
   );
endinterface

// File: rtl/imm_field_ext.sv
// Combinational immediate builder: picks the class field and extends it with
// the held prefix payload, zeros, or the field's own sign bit.
module imm_field_ext
   import imm_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SHORT_W = 4,
   parameter int MID_W   = 8,
   parameter int LONG_W  = 12
) (
   input  logic [WIDTH-1:0]  instr,
   input  imm_class_e        cls,
   input  logic              zext,
   input  logic [LONG_W-1:0] pfx,
   input  logic              pfx_valid,
   output logic [WIDTH-1:0]  imm
);

   // The opcode bits never reach the immediate.
   logic unused_opc;
   assign unused_opc = ^instr[WIDTH-1:LONG_W];

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      imm = '0;
      case (cls)
         SHORT: imm = pfx_valid
                    ? {pfx[WIDTH-SHORT_W-1:0], instr[SHORT_W-1:0]}
                    : {{(WIDTH-SHORT_W){!zext && instr[SHORT_W-1]}}, instr[SHORT_W-1:0]};
         MID:   imm = pfx_valid
                    ? {pfx[WIDTH-MID_W-1:0], instr[MID_W-1:0]}
                    : {{(WIDTH-MID_W){!zext && instr[MID_W-1]}}, instr[MID_W-1:0]};
         LONG:  imm = pfx_valid
                    ? {pfx[WIDTH-LONG_W-1:0], instr[LONG_W-1:0]}
                    : {{(WIDTH-LONG_W){!zext && instr[LONG_W-1]}}, instr[LONG_W-1:0]};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered, valid/ready immediate extender with a one-deep prefix holder
// whose payload supplies the upper bits of the next immediate.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int                WIDTH       = 16,
   parameter int                OPC_W       = IMM_OPC_W,
   parameter int                SHORT_W     = 4,
   parameter int                MID_W       = 8,
   parameter int                LONG_W      = 12,
   parameter logic [OPC_W-1:0]  LONG_OPC    = IMM_LONG_OPC,
   parameter logic [OPC_W-1:0]  PFX_OPC     = IMM_PFX_OPC,
   parameter int                PFX_TIMEOUT = 7
) (
   input logic                clk,
   input logic                rst_n,
   input logic                flush,
   imm_extend_pipe_if.slave   bus
);

   localparam int TMR_W = (PFX_TIMEOUT > 1) ? $clog2(PFX_TIMEOUT) : 1;

   if (!(LONG_W >= WIDTH - SHORT_W && SHORT_W < MID_W && MID_W < LONG_W &&
         LONG_W < WIDTH && OPC_W == IMM_OPC_W)) begin : g_bad_widths
      $error("imm_extend_pipe: illegal field width parameters");
   end

   pfx_state_e        state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [LONG_W-1:0] pfx_q, pfx_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_instr_q, out_instr_d;
   logic [WIDTH-1:0]  out_imm_q, out_imm_d;
   logic              out_prefixed_q, out_prefixed_d;

   imm_class_e        cls;
   logic [WIDTH-1:0]  imm;
   logic              accept;

   assign cls          = classify(bus.in_instr[WIDTH-1 -: OPC_W], LONG_OPC, PFX_OPC);
   assign bus.in_ready = !flush && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   imm_field_ext #(
      .WIDTH   (WIDTH),
      .SHORT_W (SHORT_W),
      .MID_W   (MID_W),
      .LONG_W  (LONG_W)
   ) u_field_ext (
      .instr     (bus.in_instr),
      .cls       (cls),
      .zext      (bus.in_zext),
      .pfx       (pfx_q),
      .pfx_valid (state_q == HELD),
      .imm       (imm)
   );

   // An accept on the expiry cycle is taken before the timeout branch, so it still consumes the prefix.
   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      pfx_d          = pfx_q;
      out_valid_d    = out_valid_q && !bus.out_ready;
      out_instr_d    = out_instr_q;
      out_imm_d      = out_imm_q;
      out_prefixed_d = out_prefixed_q;

      if (flush) begin
         state_d     = IDLE;
         timer_d     = '0;
         out_valid_d = 1'b0;
      end else if (accept && cls == PFX) begin
         state_d = HELD;
         timer_d = '0;
         pfx_d   = bus.in_instr[LONG_W-1:0];
      end else if (accept) begin
         state_d        = IDLE;
         timer_d        = '0;
         out_valid_d    = 1'b1;
         out_instr_d    = bus.in_instr;
         out_imm_d      = imm;
         out_prefixed_d = (state_q == HELD);
      end else if (state_q == HELD && PFX_TIMEOUT != 0) begin
         if (timer_q == TMR_W'(PFX_TIMEOUT - 1)) begin
            state_d = IDLE;
            timer_d = '0;
            pfx_d   = '0;
         end else begin
            timer_d = timer_q + TMR_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         pfx_q          <= '0;
         out_valid_q    <= 1'b0;
         out_instr_q    <= '0;
         out_imm_q      <= '0;
         out_prefixed_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         pfx_q          <= pfx_d;
         out_valid_q    <= out_valid_d;
         out_instr_q    <= out_instr_d;
         out_imm_q      <= out_imm_d;
         out_prefixed_q <= out_prefixed_d;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.out_instr    = out_instr_q;
   assign bus.out_imm      = out_imm_q;
   assign bus.out_prefixed = out_prefixed_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and random stimulus for imm_extend_pipe, checked against an
// arithmetic model of the immediate rules and the prefix lifetime.
module tb_imm_extend_pipe;

   localparam int TIMEOUT = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   imm_extend_pipe_if #(.WIDTH(16)) bus ();

   imm_extend_pipe #(.WIDTH(16), .PFX_TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Model of what the output register should hold, plus the prefix lifetime.
   bit          m_valid;
   logic [15:0] m_instr;
   logic [15:0] m_imm;
   bit          m_pfxd;
   bit          m_held;
   int          m_pfx;
   int          m_idle;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_imm(input logic [15:0] instr, input bit zext,
                                           input bit held, input int pfx);
      int k, field, v;
      k     = instr[15] ? 4 : (instr[15:12] == 4'h7) ? 12 : 8;
      field = int'(instr) % (1 << k);
      if (held)                                  v = pfx * (1 << k) + field;
      else if (!zext && field >= (1 << (k - 1))) v = field - (1 << k);
      else                                       v = field;
      return v[15:0];
   endfunction

   task automatic drive(input bit v, input logic [15:0] instr, input bit zext, input bit rdy);
      bus.in_valid  = v;
      bus.in_instr  = instr;
      bus.in_zext   = zext;
      bus.out_ready = rdy;
   endtask

   task automatic model_reset();
      m_valid = 0; m_instr = '0; m_imm = '0; m_pfxd = 0;
      m_held = 0; m_pfx = 0; m_idle = 0;
   endtask

   // One clock: check in_ready before the edge, advance the model, check outputs after.
   task automatic tick();
      bit exp_ready, acc;
      #1;
      exp_ready = !flush && (!m_valid || bus.out_ready);
      check("in_ready", bus.in_ready, exp_ready);
      @(posedge clk);
      acc = bus.in_valid && exp_ready;
      if (!rst_n) begin
         model_reset();
      end else if (flush) begin
         m_valid = 0; m_held = 0; m_idle = 0;
      end else begin
         if (m_valid && bus.out_ready) m_valid = 0;
         if (acc && bus.in_instr[15:12] == 4'h6) begin
            m_held = 1; m_pfx = int'(bus.in_instr[11:0]); m_idle = 0;
         end else if (acc) begin
            m_valid = 1;
            m_instr = bus.in_instr;
            m_imm   = ref_imm(bus.in_instr, bus.in_zext, m_held, m_pfx);
            m_pfxd  = m_held;
            m_held  = 0;
         end else if (m_held) begin
            m_idle++;
            if (m_idle == TIMEOUT) m_held = 0;
         end
      end
      #1;
      check("out_valid", bus.out_valid, m_valid);
      check("out_instr", bus.out_instr, m_instr);
      check("out_imm", bus.out_imm, m_imm);
      check("out_prefixed", bus.out_prefixed, m_pfxd);
   endtask

   task automatic expect_out(input string tag, input logic [15:0] imm, input bit pfxd);
      check({tag, "_valid"}, bus.out_valid, 1'b1);
      check({tag, "_imm"}, bus.out_imm, imm);
      check({tag, "_prefixed"}, bus.out_prefixed, pfxd);
   endtask

   initial begin
      drive(0, 16'h0000, 0, 1);
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_instr", bus.out_instr, 16'h0);
      check("rst_out_imm", bus.out_imm, 16'h0);
      check("rst_out_prefixed", bus.out_prefixed, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      rst_n = 1'b1;

      // Plain extension of each class.
      drive(1, 16'h8008, 0, 1); tick(); expect_out("short_sext", 16'hFFF8, 0);
      drive(1, 16'h8008, 1, 1); tick(); expect_out("short_zext", 16'h0008, 0);
      drive(1, 16'h7800, 0, 1); tick(); expect_out("long_sext", 16'hF800, 0);
      drive(1, 16'h0180, 0, 1); tick(); expect_out("mid_sext", 16'hFF80, 0);
      drive(1, 16'h0180, 1, 1); tick(); expect_out("mid_zext", 16'h0080, 0);

      // Prefix produces no output, then supplies upper bits.
      drive(1, 16'h6ABC, 0, 1); tick(); check("pfx_no_out", bus.out_valid, 1'b0);
      drive(1, 16'h8005, 1, 1); tick(); expect_out("pfx_short", 16'hABC5, 1);
      drive(1, 16'h6ABC, 0, 1); tick();
      drive(1, 16'h01F0, 0, 1); tick(); expect_out("pfx_mid", 16'hBCF0, 1);

      // Prefix expiry: 7 idle cycles drops it, 6 idle cycles keeps it.
      drive(1, 16'h6123, 0, 1); tick();
      drive(0, 16'h0000, 0, 1); repeat (7) tick();
      drive(1, 16'h8008, 0, 1); tick(); expect_out("pfx_expired", 16'hFFF8, 0);
      drive(1, 16'h6123, 0, 1); tick();
      drive(0, 16'h0000, 0, 1); repeat (6) tick();
      drive(1, 16'h8008, 0, 1); tick(); expect_out("pfx_expiry_accept", 16'h1238, 1);

      // Backpressure: outputs held, then back-to-back results.
      drive(1, 16'h8001, 0, 0);
      #1 check("bp_in_ready", bus.in_ready, 1'b0);
      repeat (5) tick();
      expect_out("bp_held", 16'h1238, 1);
      drive(1, 16'h8001, 0, 1); tick(); expect_out("bp_rel1", 16'h0001, 0);
      drive(1, 16'h8009, 1, 1); tick(); expect_out("bp_rel2", 16'h0009, 0);

      // Flush while a prefix is held drops both the prefix and the offered word.
      drive(1, 16'h6555, 0, 1); tick();
      flush = 1'b1; drive(1, 16'h8003, 0, 0); tick();
      check("flush_valid", bus.out_valid, 1'b0);
      flush = 1'b0; drive(1, 16'h8008, 0, 1); tick(); expect_out("post_flush", 16'hFFF8, 0);
      flush = 1'b1; drive(0, 16'h0000, 0, 0); tick();
      check("flush_drop_valid", bus.out_valid, 1'b0);
      flush = 1'b0;

      // Reset mid-stream.
      drive(1, 16'h8005, 0, 1); tick();
      rst_n = 1'b0; drive(1, 16'h8007, 0, 1); tick();
      check("mid_rst_valid", bus.out_valid, 1'b0);
      check("mid_rst_imm", bus.out_imm, 16'h0);
      check("mid_rst_instr", bus.out_instr, 16'h0);
      check("mid_rst_prefixed", bus.out_prefixed, 1'b0);
      rst_n = 1'b1;

      // Random traffic, prefixes biased up so chains and expiries occur.
      for (int n = 0; n < 600; n++) begin
         logic [15:0] instr;
         instr = 16'($urandom);
         if ($urandom_range(0, 9) < 3) instr[15:12] = 4'h6;
         rst_n = ($urandom_range(0, 149) != 0);
         flush = ($urandom_range(0, 39) == 0);
         drive($urandom_range(0, 9) < 6, instr, $urandom_range(0, 1) == 1,
               $urandom_range(0, 9) < 7);
         tick();
      end
      rst_n = 1'b1;
      flush = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
